// File: rtl/ysyx_23060025_wbu_if.sv
// Write-back stage port bundle: retired-instruction input from the LSU and
// commit-side outputs (GPR write, CSR read, redirect, commit pulse).
interface ysyx_23060025_wbu_if #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
);
  logic                lsu_valid_i;
  logic                wd_i;
  logic [4:0]          wreg_i;
  logic [DATA_LEN-1:0] wdata_i;
  logic [2:0]          csr_type_i;
  logic [11:0]         csr_addr_i;
  logic [DATA_LEN-1:0] csr_wdata_i;
  logic [ADDR_LEN-1:0] pc_i;
  logic [11:0]         csr_raddr_i;
  logic                wb_ready_o;
  logic                reg_wen_o;
  logic [4:0]          reg_waddr_o;
  logic [DATA_LEN-1:0] reg_wdata_o;
  logic [DATA_LEN-1:0] csr_rdata_o;
  logic                redirect_valid_o;
  logic [ADDR_LEN-1:0] redirect_pc_o;
  logic                wb_valid_o;

  modport slave (
    input  lsu_valid_i, wd_i, wreg_i, wdata_i, csr_type_i, csr_addr_i,
           csr_wdata_i, pc_i, csr_raddr_i,
    output wb_ready_o, reg_wen_o, reg_waddr_o, reg_wdata_o, csr_rdata_o,
           redirect_valid_o, redirect_pc_o, wb_valid_o
  );

  modport master (
    output lsu_valid_i, wd_i, wreg_i, wdata_i, csr_type_i, csr_addr_i,
           csr_wdata_i, pc_i, csr_raddr_i,
    input  wb_ready_o, reg_wen_o, reg_waddr_o, reg_wdata_o, csr_rdata_o,
           redirect_valid_o, redirect_pc_o, wb_valid_o
  );
endinterface

// File: rtl/ysyx_23060025_wbu.sv
// Write-back stage: latches one retired instruction, commits GPR/CSR effects in one cycle.
// Optional mcycle/minstret counters are built when WBU_PERF_CSR_EN is defined.
module ysyx_23060025_wbu #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input logic                 clock,
  input logic                 rstn,
  ysyx_23060025_wbu_if.slave  wb
);

  typedef enum logic [0:0] {WB_IDLE, WB_COMMIT} wb_state_e;

  localparam logic [2:0] CSR_W     = 3'b001;
  localparam logic [2:0] CSR_ECALL = 3'b010;
  localparam logic [2:0] CSR_MRET  = 3'b011;

  localparam logic [11:0] A_MSTATUS = 12'h300;
  localparam logic [11:0] A_MTVEC   = 12'h305;
  localparam logic [11:0] A_MEPC    = 12'h341;
  localparam logic [11:0] A_MCAUSE  = 12'h342;

  wb_state_e           state_q, state_d;
  logic                wd_q, wd_d;
  logic [4:0]          wreg_q, wreg_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic [2:0]          csr_type_q, csr_type_d;
  logic [11:0]         csr_addr_q, csr_addr_d;
  logic [DATA_LEN-1:0] csr_wdata_q, csr_wdata_d;
  logic [ADDR_LEN-1:0] pc_q, pc_d;
  logic [DATA_LEN-1:0] mstatus_q, mstatus_d;
  logic [DATA_LEN-1:0] mtvec_q, mtvec_d;
  logic [DATA_LEN-1:0] mepc_q, mepc_d;
  logic [DATA_LEN-1:0] mcause_q, mcause_d;
  logic                commit;

`ifdef WBU_PERF_CSR_EN
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  always_comb begin
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + ((state_q == WB_COMMIT) ? 64'd1 : 64'd0);
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    wreg_d      = wreg_q;
    wdata_d     = wdata_q;
    csr_type_d  = csr_type_q;
    csr_addr_d  = csr_addr_q;
    csr_wdata_d = csr_wdata_q;
    pc_d        = pc_q;
    mstatus_d   = mstatus_q;
    mtvec_d     = mtvec_q;
    mepc_d      = mepc_q;
    mcause_d    = mcause_q;
    case (state_q)
      WB_IDLE: begin
        if (wb.lsu_valid_i) begin
          state_d     = WB_COMMIT;
          wd_d        = wb.wd_i;
          wreg_d      = wb.wreg_i;
          wdata_d     = wb.wdata_i;
          csr_type_d  = wb.csr_type_i;
          csr_addr_d  = wb.csr_addr_i;
          csr_wdata_d = wb.csr_wdata_i;
          pc_d        = wb.pc_i;
        end
      end
      WB_COMMIT: begin
        state_d = WB_IDLE;
        case (csr_type_q)
          CSR_W: begin
            case (csr_addr_q)
              A_MSTATUS: mstatus_d = csr_wdata_q;
              A_MTVEC:   mtvec_d   = csr_wdata_q;
              A_MEPC:    mepc_d    = csr_wdata_q;
              A_MCAUSE:  mcause_d  = csr_wdata_q;
              default: ;
            endcase
          end
          CSR_ECALL: begin
            mepc_d   = DATA_LEN'(pc_q);
            mcause_d = DATA_LEN'(11);
          end
          default: ;
        endcase
      end
      default: state_d = WB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      state_q     <= WB_IDLE;
      wd_q        <= 1'b0;
      wreg_q      <= '0;
      wdata_q     <= '0;
      csr_type_q  <= '0;
      csr_addr_q  <= '0;
      csr_wdata_q <= '0;
      pc_q        <= '0;
      mstatus_q   <= DATA_LEN'(32'h0000_1800);
      mtvec_q     <= '0;
      mepc_q      <= '0;
      mcause_q    <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      wreg_q      <= wreg_d;
      wdata_q     <= wdata_d;
      csr_type_q  <= csr_type_d;
      csr_addr_q  <= csr_addr_d;
      csr_wdata_q <= csr_wdata_d;
      pc_q        <= pc_d;
      mstatus_q   <= mstatus_d;
      mtvec_q     <= mtvec_d;
      mepc_q      <= mepc_d;
      mcause_q    <= mcause_d;
    end
  end

  // Everything is qualified by rstn so a reset landing on COMMIT masks the commit.
  assign commit         = rstn && (state_q == WB_COMMIT);
  assign wb.wb_ready_o  = rstn && (state_q == WB_IDLE);
  assign wb.wb_valid_o  = commit;
  assign wb.reg_wen_o   = commit && wd_q && (wreg_q != 5'd0);
  assign wb.reg_waddr_o = commit ? wreg_q : 5'd0;
  assign wb.reg_wdata_o = commit ? wdata_q : '0;

  always_comb begin
    wb.redirect_valid_o = 1'b0;
    wb.redirect_pc_o    = '0;
    if (commit && csr_type_q == CSR_ECALL) begin
      wb.redirect_valid_o = 1'b1;
      wb.redirect_pc_o    = ADDR_LEN'(mtvec_q);
    end else if (commit && csr_type_q == CSR_MRET) begin
      wb.redirect_valid_o = 1'b1;
      wb.redirect_pc_o    = ADDR_LEN'(mepc_q);
    end
  end

  always_comb begin
    wb.csr_rdata_o = '0;
    if (rstn) begin
      case (wb.csr_raddr_i)
        A_MSTATUS: wb.csr_rdata_o = mstatus_q;
        A_MTVEC:   wb.csr_rdata_o = mtvec_q;
        A_MEPC:    wb.csr_rdata_o = mepc_q;
        A_MCAUSE:  wb.csr_rdata_o = mcause_q;
`ifdef WBU_PERF_CSR_EN
        12'hB00:   wb.csr_rdata_o = DATA_LEN'(mcycle_q[31:0]);
        12'hB80:   wb.csr_rdata_o = DATA_LEN'(mcycle_q[63:32]);
        12'hB02:   wb.csr_rdata_o = DATA_LEN'(minstret_q[31:0]);
        12'hB82:   wb.csr_rdata_o = DATA_LEN'(minstret_q[63:32]);
`endif
        default:   wb.csr_rdata_o = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_wbu.sv
// Testbench for ysyx_23060025_wbu: vector table with scoreboard, CSR model, corner-case sequences.
module tb_ysyx_23060025_wbu;
  logic clock = 1'b0;
  logic rstn  = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  ysyx_23060025_wbu_if #(.DATA_LEN(32), .ADDR_LEN(32)) wb ();
  ysyx_23060025_wbu #(.DATA_LEN(32), .ADDR_LEN(32)) dut (
    .clock (clock),
    .rstn  (rstn),
    .wb    (wb.slave)
  );

  typedef struct {
    logic        wd;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [2:0]  ctype;
    logic [11:0] caddr;
    logic [31:0] cwdata;
    logic [31:0] pc;
    logic        exp_wen;
    logic        exp_rv;
    logic [31:0] exp_rpc;
  } vec_t;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] rdata_old;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mstatus = 32'h0000_1800;
    m_mtvec   = 32'h0;
    m_mepc    = 32'h0;
    m_mcause  = 32'h0;
  endtask

  function automatic logic [31:0] model_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_commit(input vec_t v);
    if (v.ctype == 3'b001) begin
      case (v.caddr)
        12'h300: m_mstatus = v.cwdata;
        12'h305: m_mtvec   = v.cwdata;
        12'h341: m_mepc    = v.cwdata;
        12'h342: m_mcause  = v.cwdata;
        default: ;
      endcase
    end else if (v.ctype == 3'b010) begin
      m_mepc   = v.pc;
      m_mcause = 32'd11;
    end
  endtask

  task automatic read_csr(input string name, input logic [11:0] a, input logic [31:0] exp);
    wb.csr_raddr_i = a;
    #1;
    chk(name, wb.csr_rdata_o, exp);
  endtask

  task automatic drive(input vec_t v);
    wb.lsu_valid_i = 1'b1;
    wb.wd_i        = v.wd;
    wb.wreg_i      = v.wreg;
    wb.wdata_i     = v.wdata;
    wb.csr_type_i  = v.ctype;
    wb.csr_addr_i  = v.caddr;
    wb.csr_wdata_i = v.cwdata;
    wb.pc_i        = v.pc;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rstn = 1'b0;
    repeat (2) @(negedge clock);
    rstn = 1'b1;
    model_reset();
  endtask

  vec_t vecs[10];

  initial begin
    vecs[0] = '{1'b1, 5'd5, 32'hDEAD_BEEF, 3'b000, 12'h000, 32'h0,         32'h8000_0000, 1'b1, 1'b0, 32'h0};
    vecs[1] = '{1'b1, 5'd0, 32'h0000_1234, 3'b000, 12'h000, 32'h0,         32'h8000_0004, 1'b0, 1'b0, 32'h0};
    vecs[2] = '{1'b0, 5'd7, 32'h0000_0077, 3'b000, 12'h000, 32'h0,         32'h8000_0008, 1'b0, 1'b0, 32'h0};
    vecs[3] = '{1'b1, 5'd3, 32'h0000_0055, 3'b001, 12'h305, 32'h8000_0100, 32'h8000_000C, 1'b1, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 5'd0, 32'h0,         3'b010, 12'h341, 32'h0,         32'h8000_0040, 1'b0, 1'b1, 32'h8000_0100};
    vecs[5] = '{1'b0, 5'd0, 32'h0,         3'b011, 12'h341, 32'h0,         32'h8000_0100, 1'b0, 1'b1, 32'h8000_0040};
    vecs[6] = '{1'b1, 5'd31, 32'hFFFF_0000, 3'b001, 12'h123, 32'h0000_FFFF, 32'h8000_0044, 1'b1, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 5'd1, 32'h0,         3'b111, 12'h305, 32'h1111_1111, 32'h8000_0048, 1'b0, 1'b0, 32'h0};
    vecs[8] = '{1'b0, 5'd2, 32'h0,         3'b001, 12'h300, 32'h0000_00AA, 32'h8000_004C, 1'b0, 1'b0, 32'h0};
    vecs[9] = '{1'b0, 5'd2, 32'h0,         3'b001, 12'hB00, 32'h0000_0005, 32'h8000_0050, 1'b0, 1'b0, 32'h0};

    wb.lsu_valid_i = 1'b1;
    wb.wd_i        = 1'b1;
    wb.wreg_i      = 5'd1;
    wb.wdata_i     = 32'h1;
    wb.csr_type_i  = 3'b000;
    wb.csr_addr_i  = 12'h0;
    wb.csr_wdata_i = 32'h0;
    wb.pc_i        = 32'h0;
    wb.csr_raddr_i = 12'h300;
    model_reset();

    // Reset: every output is zero, even with lsu_valid_i high
    repeat (3) @(negedge clock);
    chk("rst_ready", {31'b0, wb.wb_ready_o}, 32'h0);
    chk("rst_wen", {31'b0, wb.reg_wen_o}, 32'h0);
    chk("rst_wbvalid", {31'b0, wb.wb_valid_o}, 32'h0);
    chk("rst_redirect", {31'b0, wb.redirect_valid_o}, 32'h0);
    chk("rst_rdata", wb.csr_rdata_o, 32'h0);
    wb.lsu_valid_i = 1'b0;
    rstn = 1'b1;
    #1;
    chk("post_rst_ready", {31'b0, wb.wb_ready_o}, 32'h1);
    read_csr("post_rst_mstatus", 12'h300, 32'h0000_1800);

    for (int i = 0; i < 10; i++) begin
      exp_t e;
      bit   got;
      @(negedge clock);
      chk($sformatf("v%0d_ready", i), {31'b0, wb.wb_ready_o}, 32'h1);
      drive(vecs[i]);
      wb.csr_raddr_i = vecs[i].caddr;
      e.wen       = vecs[i].exp_wen;
      e.waddr     = vecs[i].wreg;
      e.wdata     = vecs[i].wdata;
      e.rv        = vecs[i].exp_rv;
      e.rpc       = vecs[i].exp_rpc;
      e.rdata_old = model_read(vecs[i].caddr);
      sb.push_back(e);
      @(posedge clock);
      #1 wb.lsu_valid_i = 1'b0;
      got = 0;
      for (int k = 0; k < 4 && !got; k++) begin
        @(negedge clock);
        if (wb.wb_valid_o) got = 1;
      end
      if (!got) begin
        total++;
        bad++;
        $display("FAIL v%0d_commit: got no wb_valid_o expected a pulse within 4 cycles", i);
        void'(sb.pop_front());
      end else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_wen", i), {31'b0, wb.reg_wen_o}, {31'b0, e.wen});
        if (e.wen) begin
          chk($sformatf("v%0d_waddr", i), {27'b0, wb.reg_waddr_o}, {27'b0, e.waddr});
          chk($sformatf("v%0d_wdata", i), wb.reg_wdata_o, e.wdata);
        end
        chk($sformatf("v%0d_rv", i), {31'b0, wb.redirect_valid_o}, {31'b0, e.rv});
        if (e.rv) chk($sformatf("v%0d_rpc", i), wb.redirect_pc_o, e.rpc);
        chk($sformatf("v%0d_rd_old", i), wb.csr_rdata_o, e.rdata_old);
        chk($sformatf("v%0d_ready_busy", i), {31'b0, wb.wb_ready_o}, 32'h0);
        model_commit(vecs[i]);
      end
      @(negedge clock);
      chk($sformatf("v%0d_pulse_end", i), {31'b0, wb.wb_valid_o}, 32'h0);
      chk($sformatf("v%0d_idle_ready", i), {31'b0, wb.wb_ready_o}, 32'h1);
      read_csr($sformatf("v%0d_mstatus", i), 12'h300, m_mstatus);
      read_csr($sformatf("v%0d_mtvec", i), 12'h305, m_mtvec);
      read_csr($sformatf("v%0d_mepc", i), 12'h341, m_mepc);
      read_csr($sformatf("v%0d_mcause", i), 12'h342, m_mcause);
    end

    // lsu_valid_i held through COMMIT: second commit only after re-entering IDLE
    @(negedge clock);
    drive('{1'b1, 5'd9, 32'h0000_0909, 3'b000, 12'h0, 32'h0, 32'h8000_0060, 1'b1, 1'b0, 32'h0});
    @(negedge clock);
    chk("hold_c1", {31'b0, wb.wb_valid_o}, 32'h1);
    @(negedge clock);
    chk("hold_gap_valid", {31'b0, wb.wb_valid_o}, 32'h0);
    chk("hold_gap_ready", {31'b0, wb.wb_ready_o}, 32'h1);
    @(negedge clock);
    chk("hold_c2", {31'b0, wb.wb_valid_o}, 32'h1);
    chk("hold_c2_wen", {31'b0, wb.reg_wen_o}, 32'h1);
    wb.lsu_valid_i = 1'b0;
    @(negedge clock);
    chk("hold_end", {31'b0, wb.wb_valid_o}, 32'h0);

    // Reset asserted in the COMMIT cycle of an ECALL
    do_reset();
    drive('{1'b1, 5'd4, 32'h0000_0044, 3'b010, 12'h0, 32'h0, 32'h8000_0040, 1'b0, 1'b1, 32'h0});
    @(posedge clock);
    #1 wb.lsu_valid_i = 1'b0;
    @(negedge clock);
    rstn = 1'b0;
    #1;
    chk("rstc_rv", {31'b0, wb.redirect_valid_o}, 32'h0);
    chk("rstc_wen", {31'b0, wb.reg_wen_o}, 32'h0);
    chk("rstc_wbvalid", {31'b0, wb.wb_valid_o}, 32'h0);
    @(negedge clock);
    rstn = 1'b1;
    #1;
    chk("rstc_ready", {31'b0, wb.wb_ready_o}, 32'h1);
    read_csr("rstc_mepc", 12'h341, 32'h0);
    read_csr("rstc_mcause", 12'h342, 32'h0);
    read_csr("rstc_mstatus", 12'h300, 32'h0000_1800);

    // Performance counters: 3 commits in the first 10 cycles after reset
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive('{1'b1, 5'd6, 32'h0000_0006, 3'b000, 12'h0, 32'h0, 32'h8000_0070, 1'b1, 1'b0, 32'h0});
      @(posedge clock);
      #1 wb.lsu_valid_i = 1'b0;
      @(posedge clock);
      #1;
    end
    repeat (4) @(posedge clock);
    @(negedge clock);
`ifdef WBU_PERF_CSR_EN
    read_csr("perf_mcycle_lo", 12'hB00, 32'd10);
    read_csr("perf_mcycle_hi", 12'hB80, 32'd0);
    read_csr("perf_minstret_lo", 12'hB02, 32'd3);
    read_csr("perf_minstret_hi", 12'hB82, 32'd0);
`else
    read_csr("perf_absent_b00", 12'hB00, 32'd0);
    read_csr("perf_absent_b02", 12'hB02, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/ysyx_23060025_wbu.md
# ysyx_23060025_wbu

Write-back stage of the multi-cycle core, directly downstream of the load/store stage. It accepts one retired instruction per handshake: write-data, destination register and CSR side-effects. In a single commit cycle it drives the GPR write port, updates the machine-mode CSR file and issues the next-PC redirect for trap entry and return. It then pulses `wb_valid_o` so the fetch stage starts the next instruction.

## Interface
Parameters:
- DATA_LEN, 32, datapath width
- ADDR_LEN, 32, PC width

Ports:
- clock  in  1  single core clock; all state on rising edge
- rstn  in  1  synchronous, active-low reset
- lsu_valid_i  in  1  load/store stage has a retired instruction this cycle
- wd_i  in  1  instruction writes a GPR
- wreg_i  in  5  destination GPR index
- wdata_i  in  DATA_LEN  GPR write data
- csr_type_i  in  3  CSR op: 000 none, 001 CSRW, 010 ECALL, 011 MRET, others treated as none
- csr_addr_i  in  12  CSR target for CSRW
- csr_wdata_i  in  DATA_LEN  CSRW data
- pc_i  in  ADDR_LEN  PC of the retiring instruction
- csr_raddr_i  in  12  CSR read address from the execute stage
- wb_ready_o  out  1  stage can accept (state IDLE)
- reg_wen_o  out  1  GPR write enable
- reg_waddr_o  out  5  GPR write index
- reg_wdata_o  out  DATA_LEN  GPR write data
- csr_rdata_o  out  DATA_LEN  combinational CSR read data
- redirect_valid_o  out  1  next PC is `redirect_pc_o`, not sequential
- redirect_pc_o  out  ADDR_LEN  trap/return target
- wb_valid_o  out  1  one-cycle commit pulse to the fetch stage

## Operation
- States: WB_IDLE (reset), WB_COMMIT.
- WB_IDLE with `lsu_valid_i`=1:
  - latch wd, wreg, wdata, csr_type, csr_addr, csr_wdata and pc;
  - go to WB_COMMIT.
  - Otherwise stay in WB_IDLE.
- WB_COMMIT always returns to WB_IDLE on the next edge. All outputs are driven from the latched values.
- GPR write: `reg_wen_o` = COMMIT & wd & (wreg != 0). Writes to x0 are suppressed.
- CSR file, updated at the end of the COMMIT cycle:
  - mstatus 0x300, reset 0x0000_1800
  - mtvec 0x305, reset 0
  - mepc 0x341, reset 0
  - mcause 0x342, reset 0
- CSRW: write `csr_wdata` to the addressed CSR. Unknown addresses are ignored.
- ECALL:
  - mepc <= pc, mcause <= 11;
  - `redirect_valid_o`=1 with `redirect_pc_o` = current mtvec (the pre-update value).
- MRET: `redirect_valid_o`=1 with `redirect_pc_o` = mepc. CSRs are unchanged.
- `csr_rdata_o` is selected combinationally by `csr_raddr_i`. Unknown addresses return 0. A read during a CSRW to the same address returns the old value.
- `redirect_valid_o`, `redirect_pc_o` and `wb_valid_o` are meaningful only during COMMIT; otherwise they are 0.

## Timing
- Latency:
  - `lsu_valid_i` sampled high at edge N;
  - COMMIT occupies cycle N..N+1 with `reg_wen_o`/`wb_valid_o` high;
  - CSR updates are visible after edge N+1.
- Throughput: one instruction per 2 cycles. `wb_ready_o`=0 during COMMIT. `lsu_valid_i` asserted during COMMIT is ignored and not queued.
- Reset values: state IDLE, all CSRs as listed above.
  - Every output is 0 while `rstn`=0, including `reg_wen_o`, `wb_valid_o` and `redirect_valid_o`.
  - `wb_ready_o` is 0 while `rstn`=0.
- Reset mid-commit:
  - when `rstn`=0 at the COMMIT edge, no CSR update occurs and the state returns to IDLE;
  - the GPR write of that cycle is masked by `rstn`.
- `lsu_valid_i` held high across two IDLE visits commits two separate instructions; the upstream stage must drop it after the handshake.

## Configuration
- `WBU_PERF_CSR_EN` defined:
  - 64-bit mcycle increments every cycle with `rstn`=1;
  - 64-bit minstret increments on every COMMIT cycle;
  - both reset to 0;
  - both are readable at 0xB00/0xB80 (mcycle low/high) and 0xB02/0xB82 (minstret low/high);
  - a CSRW to these addresses is ignored.
- Undefined: the counters are absent and reads of those addresses return 0.

## Test plan
- Reset then `lsu_valid_i`=1, wd=1, wreg=5, wdata=0xDEADBEEF -> next cycle `reg_wen_o`=1, waddr=5, wdata=0xDEADBEEF, `wb_valid_o`=1 for exactly one cycle, then `wb_ready_o`=1.
- Commit with wd=1, wreg=0 -> `reg_wen_o`=0, `wb_valid_o`=1.
- CSRW 0x305 <= 0x8000_0100, then ECALL at pc 0x8000_0040 -> `redirect_pc_o`=0x8000_0100, after which mepc=0x8000_0040 and mcause=11. MRET -> `redirect_pc_o`=0x8000_0040.
- `lsu_valid_i` held high during COMMIT -> no extra commit; second commit occurs only after re-entering IDLE.
- `rstn` low in the COMMIT cycle of an ECALL -> mepc stays 0, `redirect_valid_o`=0, mstatus reads 0x1800.
- With `WBU_PERF_CSR_EN`: 3 commits over 10 cycles from reset -> minstret reads 3, mcycle reads 10. Without it, 0xB00 reads 0.
